// File: rtl/cprv_imem_if.sv
// ---------------------------------------------------------------------------
// cprv_imem_if
// Fetch interface between the IF stage (master) and the instruction memory
// responder (slave).
//   valid_req / ready_req / addr_req   : fetch request channel (byte address)
//   valid_rsp / ready_rsp / rdata_rsp  : response channel, zero-extended word
//   err_rsp                            : response flags a misaligned or
//                                        out-of-range fetch address
// ---------------------------------------------------------------------------
interface cprv_imem_if #(
  parameter int unsigned DATA_WIDTH = 64
);
  logic                  valid_req;
  logic                  ready_req;
  logic [DATA_WIDTH-1:0] addr_req;
  logic                  valid_rsp;
  logic                  ready_rsp;
  logic [DATA_WIDTH-1:0] rdata_rsp;
  logic                  err_rsp;

  modport master (
    output valid_req, addr_req, ready_rsp,
    input  ready_req, valid_rsp, rdata_rsp, err_rsp
  );

  modport slave (
    input  valid_req, addr_req, ready_rsp,
    output ready_req, valid_rsp, rdata_rsp, err_rsp
  );
endinterface

// File: rtl/cprv_imem_responder.sv
// ---------------------------------------------------------------------------
// cprv_imem_responder
// Instruction-memory responder at the far end of the fetch interface. Fetch
// requests read a word-addressed RAM; the result travels a fixed-latency read
// pipeline into an in-order, first-word fall-through response buffer. A
// credit count (pipeline + buffer occupancy) throttles ready_req so the
// pipeline never stalls and the buffer never overflows.
// Ports:
//   clk, rst_n      : clock, synchronous active-low reset
//   fetch_if        : slave side of cprv_imem_if (request/response channels)
//   load_we_i       : preload write enable (honoured in and out of reset)
//   load_addr_i     : preload word index
//   load_data_i     : preload word
// ---------------------------------------------------------------------------
module cprv_imem_responder #(
  parameter int unsigned INSTR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  cprv_imem_if.slave               fetch_if,
  input  logic                     load_we_i,
  input  logic [$clog2(DEPTH)-1:0] load_addr_i,
  input  logic [INSTR_WIDTH-1:0]   load_data_i
);

  localparam int unsigned AW         = $clog2(DEPTH);
  localparam int unsigned FIFO_DEPTH = LATENCY + 1;
  localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned NSTG       = (LATENCY > 1) ? LATENCY - 1 : 1;

  logic [INSTR_WIDTH-1:0] mem_q [DEPTH];

  logic                   ready_req_c;
  logic                   valid_rsp_c;
  logic                   accept_c;
  logic                   pop_c;
  logic                   req_err_c;
  logic [AW-1:0]          req_idx_c;
  logic [INSTR_WIDTH-1:0] rd_word_c;

  logic                   fin_vld_c;
  logic                   fin_err_c;
  logic [INSTR_WIDTH-1:0] fin_data_c;

  logic [INSTR_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
  logic                   fifo_err_q  [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       fifo_cnt_q, fifo_cnt_d;
  logic [CNT_W-1:0]       occ_q, occ_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Request decode: word index plus alignment / range error
  assign req_idx_c = fetch_if.addr_req[AW+1:2];
  assign req_err_c = (fetch_if.addr_req[1:0] != 2'b00) |
                     (|fetch_if.addr_req[DATA_WIDTH-1:AW+2]);
  assign rd_word_c = req_err_c ? '0 : mem_q[req_idx_c];

  // Credit check uses registered occupancy only; a same-cycle pop frees a slot next cycle
  assign ready_req_c = rst_n & (occ_q < CNT_W'(FIFO_DEPTH));
  assign valid_rsp_c = (fifo_cnt_q != '0);
  assign accept_c    = fetch_if.valid_req & ready_req_c;
  assign pop_c       = valid_rsp_c & fetch_if.ready_rsp;

  assign fetch_if.ready_req = ready_req_c;
  assign fetch_if.valid_rsp = valid_rsp_c;
  assign fetch_if.rdata_rsp = DATA_WIDTH'(fifo_data_q[rd_ptr_q]);
  assign fetch_if.err_rsp   = fifo_err_q[rd_ptr_q];

  // Preload port; the NBA write makes a same-cycle fetch of the word read-first
  always_ff @(posedge clk) begin
    if (load_we_i) begin
      mem_q[load_addr_i] <= load_data_i;
    end
  end

  // Read pipeline: stage 0 captures the RAM read, the buffer write is the final stage
  if (LATENCY > 1) begin : g_pipe
    logic [NSTG-1:0]        stg_vld_q;
    logic [NSTG-1:0]        stg_err_q;
    logic [INSTR_WIDTH-1:0] stg_data_q [NSTG];

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        stg_vld_q <= '0;
        stg_err_q <= '0;
        for (int k = 0; k < NSTG; k++) begin
          stg_data_q[k] <= '0;
        end
      end else begin
        stg_vld_q[0]  <= accept_c;
        stg_err_q[0]  <= req_err_c;
        stg_data_q[0] <= rd_word_c;
        for (int k = 1; k < NSTG; k++) begin
          stg_vld_q[k]  <= stg_vld_q[k-1];
          stg_err_q[k]  <= stg_err_q[k-1];
          stg_data_q[k] <= stg_data_q[k-1];
        end
      end
    end

    assign fin_vld_c  = stg_vld_q[NSTG-1];
    assign fin_err_c  = stg_err_q[NSTG-1];
    assign fin_data_c = stg_data_q[NSTG-1];
  end else begin : g_direct
    assign fin_vld_c  = accept_c;
    assign fin_err_c  = req_err_c;
    assign fin_data_c = rd_word_c;
  end

  // Next-state for buffer pointers, buffer count and total occupancy
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    occ_d      = occ_q;

    if (fin_vld_c) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop_c)     rd_ptr_d = ptr_inc(rd_ptr_q);

    case ({fin_vld_c, pop_c})
      2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase

    case ({accept_c, pop_c})
      2'b10:   occ_d = occ_q + CNT_W'(1);
      2'b01:   occ_d = occ_q - CNT_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  // Response buffer state; reset discards every buffered and in-flight entry
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      occ_q      <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data_q[i] <= '0;
        fifo_err_q[i]  <= 1'b0;
      end
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
      occ_q      <= occ_d;
      if (fin_vld_c) begin
        fifo_data_q[wr_ptr_q] <= fin_data_c;
        fifo_err_q[wr_ptr_q]  <= fin_err_c;
      end
    end
  end

endmodule

// File: tb/tb_cprv_imem_responder.sv
// ---------------------------------------------------------------------------
// tb_cprv_imem_responder
// Drives the fetch interface cycle by cycle and compares every cycle against a
// transaction-level model: a word array for the RAM and a queue of expected
// responses, each tagged with the earliest cycle it may appear.
// ---------------------------------------------------------------------------
module tb_cprv_imem_responder;

  localparam int unsigned INSTR_WIDTH = 32;
  localparam int unsigned DATA_WIDTH  = 64;
  localparam int unsigned DEPTH       = 1024;
  localparam int unsigned LATENCY     = 2;
  localparam int unsigned NWORDS      = 64;

  typedef struct {
    int unsigned     avail;
    logic            err;
    logic [63:0]     data;
  } exp_t;

  logic                     clk;
  logic                     rst_n;
  logic                     load_we;
  logic [$clog2(DEPTH)-1:0] load_addr;
  logic [INSTR_WIDTH-1:0]   load_data;

  cprv_imem_if #(.DATA_WIDTH(DATA_WIDTH)) fetch_if ();

  cprv_imem_responder #(
    .INSTR_WIDTH (INSTR_WIDTH),
    .DATA_WIDTH  (DATA_WIDTH),
    .DEPTH       (DEPTH),
    .LATENCY     (LATENCY)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fetch_if    (fetch_if),
    .load_we_i   (load_we),
    .load_addr_i (load_addr),
    .load_data_i (load_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mdl_mem [DEPTH];
  exp_t        exp_q [$];
  int unsigned cyc;
  int unsigned n_checks;
  int unsigned n_errors;
  int unsigned dut_acc;
  int unsigned mdl_acc;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  // One clock: drive inputs, check outputs, advance the model over the next edge
  task automatic run_cycle(input logic rst_v, input logic vreq, input logic [63:0] addr,
                           input logic rrsp, input logic we, input logic [9:0] la,
                           input logic [31:0] ld);
    logic exp_ready;
    logic exp_valid;
    exp_t e;
    exp_t popped;
    rst_n              = rst_v;
    fetch_if.valid_req = vreq;
    fetch_if.addr_req  = addr;
    fetch_if.ready_rsp = rrsp;
    load_we            = we;
    load_addr          = la;
    load_data          = ld;
    #1;
    exp_ready = rst_v && (exp_q.size() < LATENCY + 1);
    exp_valid = (exp_q.size() > 0) && (exp_q[0].avail <= cyc);
    check_eq("ready_req", 64'(fetch_if.ready_req), 64'(exp_ready));
    check_eq("valid_rsp", 64'(fetch_if.valid_rsp), 64'(exp_valid));
    if (exp_valid) begin
      check_eq("rdata_rsp", fetch_if.rdata_rsp, exp_q[0].data);
      check_eq("err_rsp", 64'(fetch_if.err_rsp), 64'(exp_q[0].err));
    end
    if (fetch_if.ready_req && vreq) dut_acc++;
    if (!rst_v) begin
      exp_q.delete();
    end else begin
      if (exp_valid && rrsp) popped = exp_q.pop_front();
      if (vreq && exp_ready) begin
        e.avail = cyc + LATENCY;
        e.err   = (addr[1:0] != 2'b00) || (addr >= 64'(DEPTH * 4));
        e.data  = e.err ? 64'd0 : {32'd0, mdl_mem[addr[11:2]]};
        exp_q.push_back(e);
        mdl_acc++;
      end
    end
    if (we) mdl_mem[la] = ld;
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle(input logic rrsp);
    run_cycle(1'b1, 1'b0, 64'd0, rrsp, 1'b0, 10'd0, 32'd0);
  endtask

  task automatic drain(input string tag);
    int unsigned n;
    n = 0;
    while ((exp_q.size() > 0) && (n < 50)) begin
      idle(1'b1);
      n++;
    end
    check_eq(tag, 64'(exp_q.size()), 64'd0);
    repeat (3) idle(1'b1);
  endtask

  initial begin
    logic [31:0] w;
    logic [63:0] a;
    int unsigned base;
    int unsigned r;
    logic tog;
    cyc = 0; n_checks = 0; n_errors = 0; dut_acc = 0; mdl_acc = 0;
    rst_n = 1'b0;
    fetch_if.valid_req = 1'b0;
    fetch_if.addr_req  = '0;
    fetch_if.ready_rsp = 1'b0;
    load_we = 1'b0; load_addr = '0; load_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check_eq("rst_valid", 64'(fetch_if.valid_rsp), 64'd0);
    check_eq("rst_rdata", fetch_if.rdata_rsp, 64'd0);
    check_eq("rst_err", 64'(fetch_if.err_rsp), 64'd0);
    check_eq("rst_ready", 64'(fetch_if.ready_req), 64'd0);
    @(negedge clk);

    // Preload during reset: fixed program words, distinct word 5, random rest
    for (int i = 0; i < NWORDS; i++) begin
      case (i)
        0: w = 32'h00000013;
        1: w = 32'h00100093;
        2: w = 32'h00200113;
        3: w = 32'h00300193;
        5: w = 32'h00500293;
        default: w = $urandom;
      endcase
      run_cycle(1'b0, 1'b0, 64'd0, 1'b0, 1'b1, 10'(i), w);
    end

    // Back-to-back fetch with no backpressure
    for (int i = 0; i < 4; i++) run_cycle(1'b1, 1'b1, 64'(i * 4), 1'b1, 1'b0, 10'd0, 32'd0);
    drain("t1_drain");

    // Full backpressure: three accepted, then stalled, then resumes
    base = dut_acc;
    for (int i = 0; i < 6; i++) run_cycle(1'b1, 1'b1, 64'(i * 4), 1'b0, 1'b0, 10'd0, 32'd0);
    check_eq("t2_accepts", 64'(dut_acc - base), 64'd3);
    for (int i = 0; i < 6; i++) run_cycle(1'b1, 1'b1, 64'(i * 4 + 16), 1'b1, 1'b0, 10'd0, 32'd0);
    drain("t2_drain");

    // Error addresses
    run_cycle(1'b1, 1'b1, 64'h2, 1'b1, 1'b0, 10'd0, 32'd0);
    run_cycle(1'b1, 1'b1, 64'h1000, 1'b1, 1'b0, 10'd0, 32'd0);
    run_cycle(1'b1, 1'b1, 64'hFFC, 1'b1, 1'b0, 10'd0, 32'd0);
    drain("t3_drain");

    // Alternating backpressure over 16 fetches
    base = mdl_acc;
    tog  = 1'b1;
    for (int i = 0; (i < 100) && (mdl_acc - base < 16); i++) begin
      run_cycle(1'b1, 1'b1, 64'((mdl_acc - base) * 4), tog, 1'b0, 10'd0, 32'd0);
      tog = ~tog;
    end
    check_eq("t4_accepts", 64'(mdl_acc - base), 64'd16);
    for (int i = 0; (i < 60) && (exp_q.size() > 0); i++) begin
      idle(tog);
      tog = ~tog;
    end
    drain("t4_drain");

    // Reset with responses in flight and buffered
    for (int i = 0; i < 3; i++) run_cycle(1'b1, 1'b1, 64'(i * 4 + 8), 1'b0, 1'b0, 10'd0, 32'd0);
    run_cycle(1'b0, 1'b1, 64'h0, 1'b1, 1'b0, 10'd0, 32'd0);
    #1;
    check_eq("t5_rdata_rst", fetch_if.rdata_rsp, 64'd0);
    for (int i = 0; i < 4; i++) run_cycle(1'b1, 1'b1, 64'(i * 4), 1'b1, 1'b0, 10'd0, 32'd0);
    drain("t5_drain");

    // Same-cycle preload and fetch of one word: old data first
    run_cycle(1'b1, 1'b1, 64'h14, 1'b1, 1'b1, 10'd5, 32'hDEADBEEF);
    drain("t6a_drain");
    run_cycle(1'b1, 1'b1, 64'h14, 1'b1, 1'b0, 10'd0, 32'd0);
    drain("t6b_drain");

    // Random traffic with loads, bad addresses and occasional reset
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 15);
      w = 32'($urandom_range(0, NWORDS - 1));
      if (r == 0)      a = 64'(w * 4 + 32'($urandom_range(1, 3)));
      else if (r == 1) a = (64'd1 << $urandom_range(12, 63)) | 64'(w * 4);
      else             a = 64'(w * 4);
      run_cycle(($urandom_range(0, 99) != 0), 1'($urandom), a, 1'($urandom),
                ($urandom_range(0, 7) == 0), 10'($urandom_range(0, NWORDS - 1)), $urandom);
    end
    drain("rand_drain");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
